// File: rtl/serial_shift_register.sv
// Serial-in/serial-out shift register with parallel load, parallel readout
// and shift-direction control. Serves as a bit-serial delay line or as a
// serialiser/deserialiser stage between a serial link and word-wide logic.
// Controls not needed by an instance should be tied to shift_en=1, load=0,
// dir=0 and par_in='0, which gives a plain WIDTH-stage serial delay.
module serial_shift_register #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active low
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             load,
  input  logic             dir,       // 0: toward MSB, 1: toward LSB
  input  logic [WIDTH-1:0] par_in,
  output logic             data_out,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] q;

  // Register update: async clear, then load > shift > hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= par_in;
    end else if (shift_en) begin
      if (!dir) begin
        q <= {q[WIDTH-2:0], data_in};
      end else begin
        q <= {data_in, q[WIDTH-1:1]};
      end
    end
  end

  // Serial output taps the far end for the current direction; no extra flop,
  // so a dir change moves the tap immediately.
  always_comb begin
    data_out = dir ? q[0] : q[WIDTH-1];
    par_out  = q;
  end

endmodule

// File: tb/tb_serial_shift_register.sv
// Directed bench for serial_shift_register: reset, serial delay, hold, load
// priority, direction control, async reset mid-cycle, and pulse latency at
// WIDTH=2 and WIDTH=8.
module tb_serial_shift_register;

  logic clk;
  logic reset;

  // 4-bit instance stimulus
  logic       d_in, sh_en, ld, dr;
  logic [3:0] p_in;
  logic       dout;
  logic [3:0] pout;

  // Sweep instances
  logic       d2, d8;
  logic       dout2, dout8;
  logic [1:0] pout2;
  logic [7:0] pout8;

  int n_checks = 0;
  int n_fail   = 0;

  serial_shift_register #(.WIDTH(4)) Shift_Register (
    .clk      (clk),
    .reset    (reset),
    .data_in  (d_in),
    .shift_en (sh_en),
    .load     (ld),
    .dir      (dr),
    .par_in   (p_in),
    .data_out (dout),
    .par_out  (pout)
  );

  serial_shift_register #(.WIDTH(2)) u_w2 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (d2),
    .shift_en (1'b1),
    .load     (1'b0),
    .dir      (1'b0),
    .par_in   (2'b00),
    .data_out (dout2),
    .par_out  (pout2)
  );

  serial_shift_register #(.WIDTH(8)) u_w8 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (d8),
    .shift_en (1'b1),
    .load     (1'b0),
    .dir      (1'b0),
    .par_in   (8'h00),
    .data_out (dout8),
    .par_out  (pout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    d_in  = 1'b1;
    sh_en = 1'b1;
    ld    = 1'b0;
    dr    = 1'b0;
    p_in  = 4'b0000;
    d2    = 1'b0;
    d8    = 1'b0;

    // Reset held low with clock running and data_in=1
    #1;
    check("rst_pout_t0", pout, 4'b0000);
    check("rst_dout_t0", dout, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pout", pout, 4'b0000);
      check("rst_dout", dout, 1'b0);
      check("rst_pout8", pout8, 8'h00);
    end

    // Serial delay: 1,0,1,1 then zeros
    reset = 1'b1;
    d_in = 1'b1; tick(); check("ser_e1", pout, 4'b0001);
    d_in = 1'b0; tick(); check("ser_e2", pout, 4'b0010);
    d_in = 1'b1; tick(); check("ser_e3", pout, 4'b0101);
    d_in = 1'b1; tick(); check("ser_e4", pout, 4'b1011);
    check("ser_dout_e4", dout, 1'b1);
    d_in = 1'b0; tick(); check("ser_dout_e5", dout, 1'b0); check("ser_e5", pout, 4'b0110);
    tick(); check("ser_dout_e6", dout, 1'b1); check("ser_e6", pout, 4'b1100);
    tick(); check("ser_dout_e7", dout, 1'b1); check("ser_e7", pout, 4'b1000);

    // Hold with shift_en=0 while data_in toggles
    ld = 1'b1; p_in = 4'b1011; tick(); check("hold_setup", pout, 4'b1011);
    ld = 1'b0; sh_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_in = i[0];
      tick();
      check("hold_pout", pout, 4'b1011);
      check("hold_dout", dout, 1'b1);
    end

    // Load wins over shift
    p_in = 4'b0110; ld = 1'b1; sh_en = 1'b1; d_in = 1'b1;
    tick(); check("load_prio", pout, 4'b0110);
    ld = 1'b0; d_in = 1'b0;
    tick(); check("load_then_shl", pout, 4'b1100);

    // Direction control
    ld = 1'b1; p_in = 4'b0110; tick(); check("dir_setup", pout, 4'b0110);
    ld = 1'b0; dr = 1'b1; d_in = 1'b1;
    #1; check("dir_mux_lsb", dout, 1'b0);
    tick(); check("dir_shr1", pout, 4'b1011); check("dir_dout1", dout, 1'b1);
    d_in = 1'b0;
    tick(); check("dir_shr2", pout, 4'b0101); check("dir_dout2", dout, 1'b1);
    dr = 1'b0;
    #1; check("dir_mux_msb", dout, 1'b0);

    // Async reset in the middle of a cycle
    ld = 1'b1; p_in = 4'b1111; tick(); check("arst_setup", pout, 4'b1111);
    ld = 1'b0; sh_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_pout", pout, 4'b0000);
    check("arst_dout", dout, 1'b0);
    #1 reset = 1'b1;
    tick(); check("arst_after", pout, 4'b0000);

    // Single-pulse latency at WIDTH=2 and WIDTH=8
    d2 = 1'b1; d8 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      d2 = 1'b0; d8 = 1'b0;
      check($sformatf("w2_dout_k%0d", k), dout2, (k == 1) ? 1'b1 : 1'b0);
      check($sformatf("w8_dout_k%0d", k), dout8, (k == 7) ? 1'b1 : 1'b0);
      check($sformatf("w8_pout_k%0d", k), pout8, (k < 8) ? (8'h01 << k) : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
